// File: rtl/serial_link_if.sv
// Serial link port signals: the MMU write/read bus, the serial IRQ line and the link pins.
// The slave modport is the view of the serial_link block itself.
interface serial_link_if;
   logic [15:0] iAddr;
   logic [7:0]  iData;
   logic        iWe;
   logic [7:0]  oData;
   logic        oInterrupt;
   logic        oSerialClock;
   logic        oSerialOut;
   logic        iSerialIn;
   logic        iSerialClock;

   modport master (
      output iAddr, iData, iWe, iSerialIn, iSerialClock,
      input  oData, oInterrupt, oSerialClock, oSerialOut
   );

   modport slave (
      input  iAddr, iData, iWe, iSerialIn, iSerialClock,
      output oData, oInterrupt, oSerialClock, oSerialOut
   );
endinterface

// File: rtl/serial_link.sv
// Game Boy SB/SC serial port: shifts SB out MSB-first while shifting the partner's bits in, then raises a one-cycle IRQ.
// Register reads are zero-latency; the bus is never stalled, and an external-clock transfer waits indefinitely for pin edges.
module serial_link #(
   parameter int CLK_DIV = 512
) (
   input logic          iClock,
   input logic          iReset,
   serial_link_if.slave link
);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

   typedef enum logic {IDLE, XFER} state_t;

   state_t       state, nxtState;
   logic [7:0]   sb, nxtSb;
   logic         sc0, nxtSc0;
   logic [2:0]   bitCnt, nxtBitCnt;
   logic [DW-1:0] divCnt, nxtDivCnt;
   logic         serClk, nxtSerClk;
   logic         serOut, nxtSerOut;
   logic         irq, nxtIrq;
   logic [1:0]   sinSync;
   logic [1:0]   sclkSync;
   logic         sclkPrev;

   logic wrSb, wrSc, fallEdge, riseEdge;

   assign wrSb = link.iWe && (link.iAddr == 16'hFF01);
   assign wrSc = link.iWe && (link.iAddr == 16'hFF02);

   // Internal mode takes its edges from the divider, external mode from the synchronized pin.
   assign fallEdge = (state == XFER) && (sc0 ? (divCnt == '0) : (sclkPrev && !sclkSync[1]));
   assign riseEdge = (state == XFER) && (sc0 ? (divCnt == DIV_HALF) : (!sclkPrev && sclkSync[1]));

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state    <= IDLE;
         sb       <= 8'h00;
         sc0      <= 1'b0;
         bitCnt   <= 3'd0;
         divCnt   <= '0;
         serClk   <= 1'b1;
         serOut   <= 1'b1;
         irq      <= 1'b0;
         sinSync  <= 2'b11;
         sclkSync <= 2'b11;
         sclkPrev <= 1'b1;
      end else begin
         state    <= nxtState;
         sb       <= nxtSb;
         sc0      <= nxtSc0;
         bitCnt   <= nxtBitCnt;
         divCnt   <= nxtDivCnt;
         serClk   <= nxtSerClk;
         serOut   <= nxtSerOut;
         irq      <= nxtIrq;
         sinSync  <= {sinSync[0], link.iSerialIn};
         sclkSync <= {sclkSync[0], link.iSerialClock};
         sclkPrev <= sclkSync[1];
      end
   end

   always_comb begin
      nxtState  = state;
      nxtSb     = sb;
      nxtSc0    = sc0;
      nxtBitCnt = bitCnt;
      nxtDivCnt = divCnt;
      nxtSerClk = serClk;
      nxtSerOut = serOut;
      nxtIrq    = 1'b0;
      case (state)
         IDLE: begin
            if (wrSb) nxtSb = link.iData;
            if (wrSc) begin
               nxtSc0 = link.iData[0];
               if (link.iData[7]) begin
                  nxtState  = XFER;
                  nxtBitCnt = 3'd0;
                  nxtDivCnt = '0;
               end
            end
         end
         XFER: begin
            if (sc0) nxtDivCnt = (divCnt == DIV_LAST) ? '0 : divCnt + 1'b1;
            if (fallEdge) begin
               nxtSerOut = sb[7];
               if (sc0) nxtSerClk = 1'b0;
            end
            if (riseEdge) begin
               nxtSb     = {sb[6:0], sinSync[1]};
               nxtBitCnt = bitCnt + 3'd1;
               nxtSerClk = 1'b1;
            end
            // Completion wins over an abort landing in the same cycle.
            if (riseEdge && (bitCnt == 3'd7)) begin
               nxtState  = IDLE;
               nxtIrq    = 1'b1;
               nxtSerOut = 1'b1;
               nxtSerClk = 1'b1;
               nxtDivCnt = '0;
            end else if (wrSc && !link.iData[7]) begin
               nxtState  = IDLE;
               nxtSerOut = 1'b1;
               nxtSerClk = 1'b1;
               nxtDivCnt = '0;
               nxtBitCnt = 3'd0;
            end
         end
         default: nxtState = IDLE;
      endcase
   end

   always_comb begin
      link.oData = 8'hFF;
      if (link.iAddr == 16'hFF01)      link.oData = sb;
      else if (link.iAddr == 16'hFF02) link.oData = {(state == XFER), 6'b111111, sc0};
   end

   assign link.oInterrupt   = irq;
   assign link.oSerialClock = serClk;
   assign link.oSerialOut   = serOut;
endmodule
